// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the fetch front end
//   fetch_ctrl_state_t : IDLE (may issue), REQ (request outstanding), DRAIN (waiting to discard a redirected response)
package rv32i_types;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_ctrl_state_t;
    localparam logic [3:0] RMASK_WORD = 4'hF;
endpackage

// File: rtl/redirect_arb.sv
// redirect_arb: combinational redirect priority select (commit > pending > decode)
//   commit_redirect/commit_target : committed mispredict
//   pend_valid/pend_target/pend_is_commit : redirect latched while a response drains
//   dec_redirect/dec_target : decode-predicted redirect
//   redirect_valid/redirect_target/redirect_is_commit : winning redirect
module redirect_arb (
    input  logic        commit_redirect,
    input  logic [31:0] commit_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  logic        pend_is_commit,
    input  logic        dec_redirect,
    input  logic [31:0] dec_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_target,
    output logic        redirect_is_commit
);
    // A pending redirect always outranks decode, so decode is never seen while one waits.
    always_comb begin
        redirect_valid     = commit_redirect | pend_valid | dec_redirect;
        redirect_target    = commit_redirect ? commit_target : pend_valid ? pend_target : dec_target;
        redirect_is_commit = commit_redirect | (pend_valid & pend_is_commit);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller with redirect handling
//   clk, rst            : clock, synchronous active-high reset
//   commit_redirect/target, dec_redirect/target : redirect sources
//   iq_full             : blocks new requests
//   imem_addr/rmask     : request to instruction memory; imem_resp/rdata : response
//   fetch_valid/pc/inst : push into the instruction queue
//   squash_cnt          : number of responses discarded because of a redirect
module fetch_ctrl
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h60000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_redirect,
    input  logic [31:0] commit_target,
    input  logic        dec_redirect,
    input  logic [31:0] dec_target,
    input  logic        iq_full,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst,
    output logic [15:0] squash_cnt
);
    fetch_ctrl_state_t state_q, state_d;
    logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d, pend_is_commit_q, pend_is_commit_d;
    logic [15:0] squash_q, squash_d;
    logic        redir_valid, redir_is_commit;
    logic [31:0] redir_target, sel_pc;

    redirect_arb u_arb (
        .commit_redirect    (commit_redirect),
        .commit_target      (commit_target),
        .pend_valid         (pend_valid_q),
        .pend_target        (pend_target_q),
        .pend_is_commit     (pend_is_commit_q),
        .dec_redirect       (dec_redirect),
        .dec_target         (dec_target),
        .redirect_valid     (redir_valid),
        .redirect_target    (redir_target),
        .redirect_is_commit (redir_is_commit)
    );

    assign sel_pc     = redir_valid ? redir_target : pc_q;
    assign squash_cnt = squash_q;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        req_pc_d         = req_pc_q;
        pend_valid_d     = pend_valid_q;
        pend_target_d    = pend_target_q;
        pend_is_commit_d = pend_is_commit_q;
        squash_d         = squash_q;
        imem_rmask       = 4'h0;
        fetch_valid      = 1'b0;
        imem_addr        = state_q == IDLE ? sel_pc : req_pc_q;
        case (state_q)
            IDLE: begin
                pc_d = sel_pc;
                if (!iq_full) begin
                    imem_rmask = RMASK_WORD;
                    req_pc_d   = sel_pc;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (imem_resp) begin
                    state_d = IDLE;
                    if (redir_valid) begin
                        squash_d = squash_q + 16'd1;
                        pc_d     = redir_target;
                    end else begin
                        fetch_valid = 1'b1;
                        pc_d        = req_pc_q + 32'd4;
                    end
                end else if (redir_valid) begin
                    pend_valid_d     = 1'b1;
                    pend_target_d    = redir_target;
                    pend_is_commit_d = redir_is_commit;
                    state_d          = DRAIN;
                end
            end
            DRAIN: begin
                // Arbiter output is the pending redirect unless a newer commit overrides it.
                if (imem_resp) begin
                    squash_d     = squash_q + 16'd1;
                    pc_d         = redir_target;
                    pend_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    pend_target_d    = redir_target;
                    pend_is_commit_d = redir_is_commit;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            imem_rmask  = 4'h0;
            fetch_valid = 1'b0;
            imem_addr   = RESET_PC;
        end
        fetch_pc   = fetch_valid ? req_pc_q : 32'h0;
        fetch_inst = fetch_valid ? imem_rdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC;
            req_pc_q         <= RESET_PC;
            pend_valid_q     <= 1'b0;
            pend_target_q    <= 32'h0;
            pend_is_commit_q <= 1'b0;
            squash_q         <= 16'h0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            req_pc_q         <= req_pc_d;
            pend_valid_q     <= pend_valid_d;
            pend_target_q    <= pend_target_d;
            pend_is_commit_q <= pend_is_commit_d;
            squash_q         <= squash_d;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_redirect = 1'b0;
    logic [31:0] commit_target = 32'h0;
    logic        dec_redirect = 1'b0;
    logic [31:0] dec_target = 32'h0;
    logic        iq_full = 1'b0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        fetch_valid;
    logic [31:0] fetch_pc, fetch_inst;
    logic [15:0] squash_cnt;
    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .commit_redirect(commit_redirect), .commit_target(commit_target),
        .dec_redirect(dec_redirect), .dec_target(dec_target),
        .iq_full(iq_full),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        commit_redirect = 1'b0;
        dec_redirect    = 1'b0;
        iq_full         = 1'b0;
        imem_resp       = 1'b0;
        imem_rdata      = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic plain_fetch(input logic [31:0] inst);
        tick();
        imem_resp  = 1'b1;
        imem_rdata = inst;
        tick();
        clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear();
        tick();
        @(negedge clk);
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL reset_rmask got %h exp %h", imem_rmask, 4'h0); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
        checks++; if (imem_addr !== 32'h60000000) begin errors++; $display("FAIL reset_addr got %h exp 60000000", imem_addr); end
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc got %h exp 0", fetch_pc); end
        checks++; if (fetch_inst !== 32'h0) begin errors++; $display("FAIL reset_fetch_inst got %h exp 0", fetch_inst); end
        checks++; if (squash_cnt !== 16'h0) begin errors++; $display("FAIL reset_squash got %h exp 0", squash_cnt); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_rmask !== 4'hF) begin errors++; $display("FAIL first_req_rmask got %h exp F", imem_rmask); end
        checks++; if (imem_addr !== 32'h60000000) begin errors++; $display("FAIL first_req_addr got %h exp 60000000", imem_addr); end
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] pc, inst;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pc   = 32'h60000000 + 32'(i * 4);
            inst = 32'h00100093 + 32'(i << 12);
            @(negedge clk);
            checks++; if (imem_rmask !== 4'hF) begin errors++; $display("FAIL seq%0d_rmask got %h exp F", i, imem_rmask); end
            checks++; if (imem_addr !== pc) begin errors++; $display("FAIL seq%0d_addr got %h exp %h", i, imem_addr, pc); end
            tick();
            imem_resp  = 1'b1;
            imem_rdata = inst;
            @(negedge clk);
            checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL seq%0d_busy_rmask got %h exp 0", i, imem_rmask); end
            checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq%0d_valid got %b exp 1", i, fetch_valid); end
            checks++; if (fetch_pc !== pc) begin errors++; $display("FAIL seq%0d_fetch_pc got %h exp %h", i, fetch_pc, pc); end
            checks++; if (fetch_inst !== inst) begin errors++; $display("FAIL seq%0d_fetch_inst got %h exp %h", i, fetch_inst, inst); end
            tick();
            clear();
        end
        checks++; if (squash_cnt !== 16'h0) begin errors++; $display("FAIL seq_squash got %h exp 0", squash_cnt); end
    endtask

    task automatic test_dec_squash();
        do_reset();
        plain_fetch(32'h13);
        @(negedge clk);
        checks++; if (imem_addr !== 32'h60000004) begin errors++; $display("FAIL dsq_addr got %h exp 60000004", imem_addr); end
        tick();
        imem_resp    = 1'b1;
        imem_rdata   = 32'h0000006F;
        dec_redirect = 1'b1;
        dec_target   = 32'h60000100;
        @(negedge clk);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL dsq_valid got %b exp 0", fetch_valid); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (imem_rmask !== 4'hF) begin errors++; $display("FAIL dsq_next_rmask got %h exp F", imem_rmask); end
        checks++; if (imem_addr !== 32'h60000100) begin errors++; $display("FAIL dsq_next_addr got %h exp 60000100", imem_addr); end
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL dsq_squash got %h exp 1", squash_cnt); end
        tick();
    endtask

    task automatic test_commit_drain();
        do_reset();
        plain_fetch(32'h13);
        plain_fetch(32'h13);
        tick();
        commit_redirect = 1'b1;
        commit_target   = 32'h60000200;
        @(negedge clk);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL cdr_c1_valid got %b exp 0", fetch_valid); end
        checks++; if (imem_addr !== 32'h60000008) begin errors++; $display("FAIL cdr_c1_addr got %h exp 60000008", imem_addr); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL cdr_c2_rmask got %h exp 0", imem_rmask); end
        checks++; if (imem_addr !== 32'h60000008) begin errors++; $display("FAIL cdr_c2_addr got %h exp 60000008", imem_addr); end
        tick();
        imem_resp  = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL cdr_c3_valid got %b exp 0", fetch_valid); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (imem_rmask !== 4'hF) begin errors++; $display("FAIL cdr_next_rmask got %h exp F", imem_rmask); end
        checks++; if (imem_addr !== 32'h60000200) begin errors++; $display("FAIL cdr_next_addr got %h exp 60000200", imem_addr); end
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL cdr_squash got %h exp 1", squash_cnt); end
        tick();
    endtask

    task automatic test_drain_override();
        do_reset();
        tick();
        dec_redirect = 1'b1;
        dec_target   = 32'h60000250;
        tick();
        clear();
        dec_redirect = 1'b1;
        dec_target   = 32'h60000300;
        tick();
        clear();
        commit_redirect = 1'b1;
        commit_target   = 32'h60000400;
        tick();
        clear();
        imem_resp = 1'b1;
        @(negedge clk);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL dov_valid got %b exp 0", fetch_valid); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (imem_addr !== 32'h60000400) begin errors++; $display("FAIL dov_addr got %h exp 60000400", imem_addr); end
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL dov_squash got %h exp 1", squash_cnt); end
        tick();
    endtask

    task automatic test_drain_dec_ignored();
        do_reset();
        tick();
        dec_redirect = 1'b1;
        dec_target   = 32'h60000250;
        tick();
        clear();
        dec_redirect = 1'b1;
        dec_target   = 32'h60000300;
        imem_resp    = 1'b1;
        @(negedge clk);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL ddi_valid got %b exp 0", fetch_valid); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (imem_addr !== 32'h60000250) begin errors++; $display("FAIL ddi_addr got %h exp 60000250", imem_addr); end
        tick();
    endtask

    task automatic test_commit_resp();
        do_reset();
        tick();
        imem_resp       = 1'b1;
        imem_rdata      = 32'h13;
        commit_redirect = 1'b1;
        commit_target   = 32'h60000900;
        @(negedge clk);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL crs_valid got %b exp 0", fetch_valid); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (imem_addr !== 32'h60000900) begin errors++; $display("FAIL crs_addr got %h exp 60000900", imem_addr); end
        checks++; if (squash_cnt !== 16'd1) begin errors++; $display("FAIL crs_squash got %h exp 1", squash_cnt); end
        tick();
    endtask

    task automatic test_iq_full();
        do_reset();
        iq_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL iqf%0d_rmask got %h exp 0", i, imem_rmask); end
            tick();
        end
        iq_full = 1'b0;
        @(negedge clk);
        checks++; if (imem_rmask !== 4'hF) begin errors++; $display("FAIL iqf_rel_rmask got %h exp F", imem_rmask); end
        checks++; if (imem_addr !== 32'h60000000) begin errors++; $display("FAIL iqf_rel_addr got %h exp 60000000", imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL iqf_single_rmask got %h exp 0", imem_rmask); end
        imem_resp = 1'b1;
        tick();
        clear();
        iq_full      = 1'b1;
        dec_redirect = 1'b1;
        dec_target   = 32'h60000700;
        tick();
        clear();
        iq_full = 1'b1;
        @(negedge clk);
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL iqf_redir_rmask got %h exp 0", imem_rmask); end
        tick();
        iq_full = 1'b0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h60000700) begin errors++; $display("FAIL iqf_redir_addr got %h exp 60000700", imem_addr); end
        tick();
    endtask

    task automatic test_rst_mid();
        do_reset();
        plain_fetch(32'h13);
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_rmask !== 4'h0) begin errors++; $display("FAIL rmid_rmask got %h exp 0", imem_rmask); end
        tick();
        rst     = 1'b0;
        iq_full = 1'b1;
        tick();
        imem_resp  = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rmid_stray_valid got %b exp 0", fetch_valid); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (squash_cnt !== 16'h0) begin errors++; $display("FAIL rmid_squash got %h exp 0", squash_cnt); end
        checks++; if (imem_rmask !== 4'hF) begin errors++; $display("FAIL rmid_req_rmask got %h exp F", imem_rmask); end
        checks++; if (imem_addr !== 32'h60000000) begin errors++; $display("FAIL rmid_req_addr got %h exp 60000000", imem_addr); end
        tick();
    endtask

    task automatic test_pc_wrap();
        do_reset();
        dec_redirect = 1'b1;
        dec_target   = 32'hFFFFFFFC;
        @(negedge clk);
        checks++; if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr got %h exp FFFFFFFC", imem_addr); end
        tick();
        clear();
        imem_resp  = 1'b1;
        imem_rdata = 32'h00000073;
        @(negedge clk);
        checks++; if (fetch_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_fetch_pc got %h exp FFFFFFFC", fetch_pc); end
        tick();
        clear();
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 00000000", imem_addr); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_dec_squash();
        test_commit_drain();
        test_drain_override();
        test_drain_dec_ignored();
        test_commit_resp();
        test_iq_full();
        test_rst_mid();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
